div_seq6: RTL and testbench

Sequential 6-bit unsigned restoring divider: the inverse arithmetic path to the team's 6-bit prefix adder. It accepts a dividend/divisor pair on a start pulse and runs one quotient bit per clock. It uses a 7-bit parallel-prefix subtractor for the trial subtraction. It sits beside the adder in the arithmetic datapath and returns quotient and remainder with a one-cycle done pulse.

---
 rtl/div_pkg.sv | 16 +
 rtl/div_seq6_prefix_sub7.sv | 52 +++++
 rtl/div_seq6.sv | 113 +++++++++++
 tb/tb_div_seq6.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the sequential divider.
// Imported by the top and its trial subtractor.
package div_pkg;

  localparam int WIDTH = 6;
  localparam int CNT_W = 3;

  localparam logic [CNT_W-1:0] LAST_ITER = 3'd5;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/div_seq6_prefix_sub7.sv
// 7-bit a - b as a + ~b + 1 on a Sklansky prefix tree.
// The +1 carry-in is folded into the bit-0 generate term.
module prefix_sub7 (
  input  logic [6:0] i_a,
  input  logic [6:0] i_b,
  output logic [6:0] o_d,
  output logic       o_cout
);

  logic [6:0] nb;
  logic [6:0] p;
  logic [6:1] g;
  logic       g0c;

  assign nb  = ~i_b;
  assign p   = i_a ^ nb;
  assign g   = i_a[6:1] & nb[6:1];
  assign g0c = i_a[0] | nb[0];

  // level 1: span 1
  logic g10, g32, p32, g54, p54;
  assign g10 = g[1] | (p[1] & g0c);
  assign g32 = g[3] | (p[3] & g[2]);
  assign p32 = p[3] & p[2];
  assign g54 = g[5] | (p[5] & g[4]);
  assign p54 = p[5] & p[4];

  // level 2: span 2
  logic g20, g30, g64, p64;
  assign g20 = g[2] | (p[2] & g10);
  assign g30 = g32  | (p32  & g10);
  assign g64 = g[6] | (p[6] & g54);
  assign p64 = p[6] & p54;

  // level 3: span 4
  logic g40, g50, g60;
  assign g40 = g[4] | (p[4] & g30);
  assign g50 = g54  | (p54  & g30);
  assign g60 = g64  | (p64  & g30);

  assign o_d = {
    p[6] ^ g50,
    p[5] ^ g40,
    p[4] ^ g30,
    p[3] ^ g20,
    p[2] ^ g10,
    p[1] ^ g0c,
    ~p[0]
  };
  assign o_cout = g60;

endmodule

// File: rtl/div_seq6.sv
// 6-bit unsigned restoring divider, one quotient bit per clock.
// Results and done pulse are registered on the edge entering DONE.
module div_seq6
  import div_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder,
  output logic             o_div_zero
);

  state_t state, state_nxt;

  logic [WIDTH:0]   r;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] d;
  logic [CNT_W-1:0] cnt;

  logic accept, iterate, last;
  logic [WIDTH:0]   t, s, r_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic             cout;

  assign t = {r[WIDTH-1:0], q[WIDTH-1]};

  prefix_sub7 u_sub (
    .i_a    (t),
    .i_b    ({1'b0, d}),
    .o_d    (s),
    .o_cout (cout)
  );

  // no borrow means the trial subtraction fits
  assign r_nxt = cout ? s : t;
  assign q_nxt = {q[WIDTH-2:0], cout};
  assign last  = (cnt == LAST_ITER);

  // the top remainder bit is provably zero once restored
  logic [1:0] unused_msb;
  assign unused_msb = {r[WIDTH], r_nxt[WIDTH]};

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (i_start) state_nxt = RUN;
      RUN:  if (last)    state_nxt = DONE;
      DONE: state_nxt = i_start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_busy  = 1'b0;
    accept  = 1'b0;
    iterate = 1'b0;
    unique case (state)
      IDLE: accept = i_start;
      RUN: begin
        o_busy  = 1'b1;
        iterate = 1'b1;
      end
      DONE: accept = i_start;
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r           <= '0;
      q           <= '0;
      d           <= '0;
      cnt         <= '0;
      o_done      <= 1'b0;
      o_quotient  <= '0;
      o_remainder <= '0;
      o_div_zero  <= 1'b0;
    end else begin
      unique case (1'b1)
        accept: begin
          r          <= '0;
          q          <= i_dividend;
          d          <= i_divisor;
          cnt        <= '0;
          o_div_zero <= (i_divisor == '0);
          o_done     <= 1'b0;
        end
        iterate: begin
          r      <= r_nxt;
          q      <= q_nxt;
          cnt    <= cnt + 1'b1;
          o_done <= last;
          if (last) begin
            o_quotient  <= q_nxt;
            o_remainder <= r_nxt[WIDTH-1:0];
          end
        end
        default: o_done <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq6.sv
// Scoreboard bench for div_seq6: driver predicts results, monitor
// checks every cycle after the clock edge.
module tb_div_seq6;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_start = 1'b0;
  logic [5:0] i_dividend = '0;
  logic [5:0] i_divisor = '0;
  logic       o_busy, o_done, o_div_zero;
  logic [5:0] o_quotient, o_remainder;

  div_seq6 dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_start     (i_start),
    .i_dividend  (i_dividend),
    .i_divisor   (i_divisor),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_quotient  (o_quotient),
    .o_remainder (o_remainder),
    .o_div_zero  (o_div_zero)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [5:0] q;
    logic [5:0] r;
    int         de;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         failures = 0;
  int         edge_cnt = 0;
  int         acc_edge = -100;
  int         free_edge = 0;
  logic [5:0] held_q = '0;
  logic [5:0] held_r = '0;
  logic       exp_dz = 1'b0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s edge=%0d actual=%0d required=%0d",
               name, edge_cnt, act, exp);
    end
  endtask

  function automatic void ref_div(input int n, input int dv,
                                  output logic [5:0] q,
                                  output logic [5:0] r);
    if (dv == 0) begin
      q = 6'd63;
      r = 6'(n);
    end else begin
      q = 6'(n / dv);
      r = 6'(n % dv);
    end
  endfunction

  // Monitor: every edge, compare all outputs with the model.
  initial begin
    exp_t e;
    logic exp_done;
    forever begin
      @(posedge i_clk);
      edge_cnt++;
      #1;
      exp_done = 1'b0;
      if (sb.size() > 0 && sb[0].de == edge_cnt) begin
        e = sb.pop_front();
        held_q = e.q;
        held_r = e.r;
        exp_done = 1'b1;
      end
      chk("done", o_done, exp_done);
      chk("busy", o_busy,
          (edge_cnt >= acc_edge && edge_cnt <= acc_edge + 5));
      chk("quotient", o_quotient, held_q);
      chk("remainder", o_remainder, held_r);
      chk("div_zero", o_div_zero, exp_dz);
    end
  end

  task automatic step(input bit rst, input bit st,
                      input logic [5:0] n, input logic [5:0] dv,
                      output bit acc);
    int e;
    logic [5:0] q, r;
    @(negedge i_clk);
    i_rst = rst;
    i_start = st;
    i_dividend = n;
    i_divisor = dv;
    e = edge_cnt + 1;
    acc = 1'b0;
    if (rst) begin
      sb.delete();
      held_q = '0;
      held_r = '0;
      exp_dz = 1'b0;
      acc_edge = -100;
      free_edge = e + 1;
    end else if (st && e >= free_edge) begin
      acc = 1'b1;
      ref_div(int'(n), int'(dv), q, r);
      sb.push_back('{q: q, r: r, de: e + 6});
      exp_dz = (dv == 0);
      acc_edge = e;
      free_edge = e + 7;
    end
  endtask

  task automatic idle(input int k, input bit noisy);
    bit a;
    for (int i = 0; i < k; i++)
      step(1'b0, noisy ? 1'($urandom_range(0, 1)) : 1'b0,
           6'($urandom), 6'($urandom), a);
  endtask

  // Issue one operation; start-noise during busy must be ignored.
  task automatic run_one(input logic [5:0] n, input logic [5:0] dv,
                         input bit noisy);
    bit a;
    int tries;
    tries = 0;
    a = 1'b0;
    while (!a && tries < 10) begin
      step(1'b0, 1'b1, n, dv, a);
      tries++;
    end
    chk("accept", a, 1'b1);
    idle(6, noisy);
  endtask

  initial begin
    bit a;
    step(1'b1, 1'b0, '0, '0, a);
    step(1'b1, 1'b0, '0, '0, a);

    run_one(6'd45, 6'd7, 1'b0);
    idle(1, 1'b0);
    run_one(6'd63, 6'd1, 1'b1);
    run_one(6'd5, 6'd9, 1'b0);
    idle(2, 1'b0);
    run_one(6'd37, 6'd0, 1'b0);
    idle(1, 1'b0);

    // back-to-back with start held high
    step(1'b0, 1'b1, 6'd60, 6'd7, a);
    chk("b2b_accept", a, 1'b1);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 6'd50, 6'd5, a);
    chk("b2b_second", a, 1'b1);
    idle(8, 1'b0);

    // reset aborts an operation mid-run
    step(1'b0, 1'b1, 6'd40, 6'd3, a);
    idle(2, 1'b0);
    step(1'b1, 1'b0, '0, '0, a);
    idle(3, 1'b0);
    run_one(6'd40, 6'd3, 1'b0);
    idle(1, 1'b0);

    for (int n = 0; n < 64; n++)
      for (int dv = 0; dv < 64; dv++)
        run_one(6'(n), 6'(dv), 1'b1);

    for (int i = 0; i < 200; i++) begin
      run_one(6'($urandom), 6'($urandom), 1'b1);
      idle($urandom_range(0, 2), 1'b0);
    end

    for (int i = 0; i < 20 && sb.size() > 0; i++) idle(1, 1'b0);
    chk("drain", sb.size(), 0);
    idle(1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
